// File: rtl/mpsoc_msi_wb_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mpsoc_msi_wb_bus_arbiter_if
// Bundle of the Wishbone B3 signals around the N:1 shared-bus arbiter.
//   m_*_i / m_*_o : packed per-master request lanes and per-master terminations
//                   (master k at [k*W +: W]); m_dat_o is broadcast to all.
//   s_*_o / s_*_i : the single shared slave port.
// Modports:
//   slave  : the arbiter (it is the slave of the N masters and drives the
//            shared slave port).
//   master : the environment, i.e. the masters plus the shared slave.
// Handshake: a master owns a transfer while cyc&stb are high; the transfer
// completes in the cycle where exactly one of ack/err/rty is high (sampled at
// the next rising clk edge). cyc may stay high across beats to hold the bus.
// -----------------------------------------------------------------------------
interface mpsoc_msi_wb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS-1:0]          m_cyc_i;
  logic [NUM_MASTERS-1:0]          m_stb_i;
  logic [NUM_MASTERS-1:0]          m_we_i;
  logic [NUM_MASTERS*AW-1:0]       m_adr_i;
  logic [NUM_MASTERS*DW-1:0]       m_dat_i;
  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel_i;
  logic [NUM_MASTERS*3-1:0]        m_cti_i;
  logic [NUM_MASTERS*2-1:0]        m_bte_i;
  logic [DW-1:0]                   m_dat_o;
  logic [NUM_MASTERS-1:0]          m_ack_o;
  logic [NUM_MASTERS-1:0]          m_err_o;
  logic [NUM_MASTERS-1:0]          m_rty_o;

  logic                            s_cyc_o;
  logic                            s_stb_o;
  logic                            s_we_o;
  logic [AW-1:0]                   s_adr_o;
  logic [DW-1:0]                   s_dat_o;
  logic [DW/8-1:0]                 s_sel_o;
  logic [2:0]                      s_cti_o;
  logic [1:0]                      s_bte_o;
  logic [DW-1:0]                   s_dat_i;
  logic                            s_ack_i;
  logic                            s_err_i;
  logic                            s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/mpsoc_msi_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mpsoc_msi_wb_bus_arbiter
// N-master to 1-slave Wishbone B3 shared-bus controller. Round-robin
// arbitration starting after the last owner; the grant is held for the whole
// cyc of the owner so bursts and RMW sequences stay atomic.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : Wishbone bundle (slave modport), see the interface file
//   grant      : one-hot owner (registered)
//   selection  : owner index (registered)
//   active     : bus currently owned
//   timeout_o  : one-cycle pulse on a forced error (0 when feature disabled)
//   dbg_state  : current FSM state, for observation only
// Optional feature: define MSI_ARB_TIMEOUT_EN to enable the stalled-transfer
// timeout (forced err after TIMEOUT_CYCLES unterminated strobe cycles, then a
// DRAIN state until the owner releases cyc).
// -----------------------------------------------------------------------------
module mpsoc_msi_wb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  mpsoc_msi_wb_bus_arbiter_if.slave      bus,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] selection,
  output logic                           active,
  output logic                           timeout_o,
  output logic [1:0]                     dbg_state
);

  localparam int SW   = $clog2(NUM_MASTERS);
  localparam int SELW = DW / 8;

`ifdef MSI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_d;
  logic [SW-1:0]           selection_d;
  logic                    active_d;
  logic [SW-1:0]           ptr, ptr_d;

  // Round-robin pick: first requesting master at or above ptr, wrapping.
  logic                    pick_found;
  logic [SW-1:0]           pick_idx;
  int                      idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!pick_found && bus.m_cyc_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = SW'(idx);
      end
    end
  end

  // Owner's request lanes, muxed by the registered selection.
  logic            owner_cyc, owner_stb, owner_we;
  logic [AW-1:0]   owner_adr;
  logic [DW-1:0]   owner_dat;
  logic [SELW-1:0] owner_sel;
  logic [2:0]      owner_cti;
  logic [1:0]      owner_bte;
  logic            any_term;
  logic [SW-1:0]   ptr_next;

  always_comb begin
    owner_cyc = bus.m_cyc_i[selection];
    owner_stb = bus.m_stb_i[selection];
    owner_we  = bus.m_we_i[selection];
    owner_adr = bus.m_adr_i[int'(selection)*AW +: AW];
    owner_dat = bus.m_dat_i[int'(selection)*DW +: DW];
    owner_sel = bus.m_sel_i[int'(selection)*SELW +: SELW];
    owner_cti = bus.m_cti_i[int'(selection)*3 +: 3];
    owner_bte = bus.m_bte_i[int'(selection)*2 +: 2];
    any_term  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    // Pointer moves to the master just after the releasing owner.
    ptr_next  = (int'(selection) == NUM_MASTERS-1) ? '0 : selection + SW'(1);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    selection_d = selection;
    active_d    = active;
    ptr_d       = ptr;
    timeout_o   = 1'b0;
`ifdef MSI_ARB_TIMEOUT_EN
    tmo_cnt_d   = '0;
`endif

    // Data-path fields follow the selection at all times; only cyc/stb and
    // terminations are qualified by ownership.
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = owner_we;
    bus.s_adr_o = owner_adr;
    bus.s_dat_o = owner_dat;
    bus.s_sel_o = owner_sel;
    bus.s_cti_o = owner_cti;
    bus.s_bte_o = owner_bte;
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OWN;
          grant_d     = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          selection_d = pick_idx;
          active_d    = 1'b1;
        end
      end

      OWN: begin
        bus.s_cyc_o = owner_cyc;
        bus.s_stb_o = owner_stb;
        // grant is one-hot on the owner, so it doubles as the return mask.
        bus.m_ack_o = bus.s_ack_i ? grant : '0;
        bus.m_err_o = bus.s_err_i ? grant : '0;
        bus.m_rty_o = bus.s_rty_i ? grant : '0;
`ifdef MSI_ARB_TIMEOUT_EN
        if (owner_cyc && owner_stb && !any_term) begin
          if (tmo_cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
            // A slave termination in this same cycle would have taken the
            // other branch, so the real response always wins.
            bus.m_err_o = grant;
            timeout_o   = 1'b1;
            state_d     = DRAIN;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
          end
        end
`endif
        if (!owner_cyc) begin
          state_d  = IDLE;
          grant_d  = '0;
          active_d = 1'b0;
          ptr_d    = ptr_next;
        end
      end

`ifdef MSI_ARB_TIMEOUT_EN
      DRAIN: begin
        // Slave port is parked; wait for the owner to give up its cycle.
        if (!owner_cyc) begin
          state_d  = IDLE;
          grant_d  = '0;
          active_d = 1'b0;
          ptr_d    = ptr_next;
        end
      end
`endif

      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      selection <= '0;
      active    <= 1'b0;
      ptr       <= '0;
`ifdef MSI_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      selection <= selection_d;
      active    <= active_d;
      ptr       <= ptr_d;
`ifdef MSI_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mpsoc_msi_wb_bus_arbiter.sv
module tb_mpsoc_msi_wb_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [N-1:0] grant;
  logic [1:0] selection;
  logic       active;
  logic       timeout_o;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mpsoc_msi_wb_bus_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  mpsoc_msi_wb_bus_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant     (grant),
    .selection (selection),
    .active    (active),
    .timeout_o (timeout_o),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];   // expected one-hot grant of each new ownership
  logic         active_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every rising edge of active is a new owner; compare with the queue head.
  always @(negedge clk) begin
    if (rst) begin
      active_q = 1'b0;
    end else begin
      if (active && !active_q) begin
        if (exp_q.size() == 0) begin
          chk("grant_order_unexpected", 32'(grant), 32'hffff_ffff);
        end else begin
          chk("grant_order", 32'(grant), 32'(exp_q.pop_front()));
        end
      end
      active_q = active;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic on, input logic we,
                     input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[k]          = on;
    bus.m_stb_i[k]          = on;
    bus.m_we_i[k]           = we;
    bus.m_adr_i[k*AW +: AW] = adr;
    bus.m_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  int order [4] = '{0, 1, 3, 0};
  int m;

  initial begin
    rst         = 1'b1;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_cti_i = '0;
    bus.m_bte_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_selection", 32'(selection), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_s_cyc", 32'(bus.s_cyc_o), 0);
    chk("rst_s_stb", 32'(bus.s_stb_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    tick();
    rst = 1'b0;

    // Single master 2: grant one cycle after cyc, ack routed only to it
    tick();
    req(2, 1'b1, 1'b0, 32'h2000_0000, 3'b000);
    exp_q.push_back(oh(2));
    @(negedge clk);
    chk("t1_grant_latency", 32'(grant), 0);
    chk("t1_s_cyc_latency", 32'(bus.s_cyc_o), 0);
    tick();
    @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_selection", 32'(selection), 2);
    chk("t1_s_cyc", 32'(bus.s_cyc_o), 1);
    chk("t1_s_stb", 32'(bus.s_stb_o), 1);
    chk("t1_s_adr", bus.s_adr_o, 32'h2000_0000);
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hCAFE_0002;
    @(negedge clk);
    chk("t1_m_ack", 32'(bus.m_ack_o), 32'h4);
    chk("t1_m_dat", bus.m_dat_o, 32'hCAFE_0002);
    chk("t1_m_err", 32'(bus.m_err_o), 0);
    tick();
    bus.s_ack_i = 1'b0;
    req(2, 1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("t1_drop_s_cyc", 32'(bus.s_cyc_o), 0);
    chk("t1_drop_m_ack", 32'(bus.m_ack_o), 0);
    tick();
    @(negedge clk);
    chk("t1_idle_active", 32'(active), 0);
    chk("t1_idle_grant", 32'(grant), 0);

    // Round-robin among 0,1,3 with one dead cycle per handoff
    pulse_reset();
    req(0, 1'b1, 1'b0, 32'h10, 3'b000);
    req(1, 1'b1, 1'b0, 32'h14, 3'b000);
    req(3, 1'b1, 1'b0, 32'h1C, 3'b000);
    for (int g = 0; g < 4; g++) exp_q.push_back(oh(order[g]));
    for (int g = 0; g < 4; g++) begin
      m = order[g];
      tick();
      @(negedge clk);
      chk("t2_active", 32'(active), 1);
      tick();
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      chk("t2_m_ack", 32'(bus.m_ack_o), 32'(oh(m)));
      tick();
      bus.s_ack_i = 1'b0;
      req(m, 1'b0, 1'b0, 32'h0, 3'b000);
      tick();
      if (g < 3) begin
        req(m, 1'b1, 1'b0, 32'h10 + 32'(4 * m), 3'b000);
      end else begin
        req(1, 1'b0, 1'b0, 32'h0, 3'b000);
        req(3, 1'b0, 1'b0, 32'h0, 3'b000);
      end
      @(negedge clk);
      chk("t2_dead_cycle", 32'(active), 0);
    end

    // Master 1 burst while master 0 waits; ptr is now 1
    req(1, 1'b1, 1'b0, 32'h100, 3'b010);
    req(0, 1'b1, 1'b1, 32'h9000, 3'b000);
    bus.m_dat_i[0 +: 32] = 32'h1234_5678;
    bus.m_sel_i[0 +: 4]  = 4'hF;
    bus.m_bte_i[0 +: 2]  = 2'b01;
    exp_q.push_back(oh(1));
    exp_q.push_back(oh(0));
    tick();
    @(negedge clk);
    chk("t3_grant_m1", 32'(grant), 32'h2);
    for (int b = 0; b < 4; b++) begin
      tick();
      req(1, 1'b1, 1'b0, 32'h100 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'hB0 + 32'(b);
      @(negedge clk);
      chk("t3_burst_ack", 32'(bus.m_ack_o), 32'h2);
      chk("t3_burst_adr", bus.s_adr_o, 32'h100 + 32'(4 * b));
      chk("t3_burst_cti", 32'(bus.s_cti_o), (b == 3) ? 32'h7 : 32'h2);
    end
    tick();
    bus.s_ack_i = 1'b0;
    req(1, 1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("t3_hold_grant", 32'(grant), 32'h2);
    chk("t3_drop_s_cyc", 32'(bus.s_cyc_o), 0);
    tick();
    @(negedge clk);
    chk("t3_dead_cycle", 32'(active), 0);
    tick();
    @(negedge clk);
    chk("t3_grant_m0", 32'(grant), 32'h1);
    chk("t3_s_we", 32'(bus.s_we_o), 1);
    chk("t3_s_dat", bus.s_dat_o, 32'h1234_5678);
    chk("t3_s_sel", 32'(bus.s_sel_o), 32'hF);
    chk("t3_s_bte", 32'(bus.s_bte_o), 32'h1);
    chk("t3_s_adr", bus.s_adr_o, 32'h9000);
    tick();
    req(0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();

    // Reset in the middle of a master-3 burst
    req(3, 1'b1, 1'b0, 32'h300, 3'b010);
    exp_q.push_back(oh(3));
    tick();
    @(negedge clk);
    chk("t4_grant_m3", 32'(grant), 32'h8);
    tick();
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("t4_ack_m3", 32'(bus.m_ack_o), 32'h8);
    tick();
    rst = 1'b1;
    req(0, 1'b1, 1'b0, 32'h40, 3'b000);
    req(1, 1'b1, 1'b0, 32'h44, 3'b000);
    tick();
    @(negedge clk);
    chk("t4_rst_grant", 32'(grant), 0);
    chk("t4_rst_active", 32'(active), 0);
    chk("t4_rst_s_cyc", 32'(bus.s_cyc_o), 0);
    chk("t4_rst_m_ack", 32'(bus.m_ack_o), 0);
    tick();
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    exp_q.push_back(oh(0));
    tick();
    @(negedge clk);
    chk("t4_after_rst_grant", 32'(grant), 32'h1);
    tick();
    req(0, 1'b0, 1'b0, 32'h0, 3'b000);
    req(1, 1'b0, 1'b0, 32'h0, 3'b000);
    req(3, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

`ifdef MSI_ARB_TIMEOUT_EN
    // Slave never answers: forced error on the 8th strobe cycle
    pulse_reset();
    req(2, 1'b1, 1'b0, 32'h2200, 3'b000);
    exp_q.push_back(oh(2));
    for (int s = 1; s <= TO; s++) begin
      tick();
      @(negedge clk);
      chk("t5_m_err", 32'(bus.m_err_o), (s == TO) ? 32'h4 : 32'h0);
      chk("t5_timeout", 32'(timeout_o), (s == TO) ? 32'h1 : 32'h0);
    end
    tick();
    @(negedge clk);
    chk("t5_drain_s_cyc", 32'(bus.s_cyc_o), 0);
    chk("t5_drain_s_stb", 32'(bus.s_stb_o), 0);
    chk("t5_drain_grant", 32'(grant), 32'h4);
    chk("t5_drain_timeout", 32'(timeout_o), 0);
    tick();
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("t5_drain_no_ack", 32'(bus.m_ack_o), 0);
    tick();
    bus.s_ack_i = 1'b0;
    req(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    @(negedge clk);
    chk("t5_exit_active", 32'(active), 0);

    // Ack in the expiry cycle wins over the forced error
    req(2, 1'b1, 1'b0, 32'h2204, 3'b000);
    exp_q.push_back(oh(2));
    for (int s = 1; s <= TO; s++) begin
      tick();
      if (s == TO) bus.s_ack_i = 1'b1;
      @(negedge clk);
      if (s == TO) begin
        chk("t6_ack", 32'(bus.m_ack_o), 32'h4);
        chk("t6_no_err", 32'(bus.m_err_o), 0);
        chk("t6_no_timeout", 32'(timeout_o), 0);
      end
    end
    tick();
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    chk("t6_still_own", 32'(bus.s_cyc_o), 1);
    req(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();
    @(negedge clk);
    chk("t6_exit_active", 32'(active), 0);
`endif

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
